branch_resolver_v3: RTL and testbench

Parametrised branch resolution unit for the RV32 pipeline, sitting at the end of Decode and feeding redirect information back to Fetch. It evaluates all six RV32I conditional branches plus JAL/JALR, computes the resolved target and the redirect PC, and detects mispredictions against the Fetch-stage guess. An optional registered compare stage handles wide datapaths. The block also contains a PC-indexed table of 2-bit saturating counters (BHT) that Fetch reads and that resolved branches train, plus saturating performance counters.

---
 rtl/branch_resolver_v3.sv | 97 +++++++++
 tb/tb_branch_resolver_v3.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver_v3.sv
// branch_resolver_v3: RV32/64 branch/jump resolver with optional compare register, 2-bit BHT and saturating perf counters
module branch_resolver_v3 #(
  parameter int XLEN = 32,
  parameter int PIPE = 0,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic [XLEN-1:0]  res_target,
  output logic [XLEN-1:0]  res_redirect_pc,
  output logic             res_mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IW = $clog2(BHT_ENTRIES);
  typedef struct packed {
    logic            v;
    logic            tk;
    logic            mp;
    logic            cn;
    logic [IW-1:0]   ix;
    logic [XLEN-1:0] tg;
    logic [XLEN-1:0] rd;
  } res_t;
  logic w_br, w_jal, w_jalr, w_f3ok, w_cond, w_tk, w_unused;
  logic [XLEN-1:0] w_bimm, w_jimm, w_iimm, w_tg;
  res_t w_s0, w_nx, r_s1, r_res;
  logic [1:0] r_bht [BHT_ENTRIES];
  logic [CNT_W-1:0] r_bc, r_mc;
  always_comb begin
    w_br = instr[6:0] == 7'b1100011;
    w_jal = instr[6:0] == 7'b1101111;
    w_jalr = instr[6:0] == 7'b1100111;
    w_f3ok = instr[14:13] != 2'b01;
    w_bimm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    w_jimm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    w_iimm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    w_cond = instr[14] ? (instr[13] ? rs1_val < rs2_val : $signed(rs1_val) < $signed(rs2_val)) : rs1_val == rs2_val;
    w_tk = w_br ? w_f3ok & (w_cond ^ instr[12]) : w_jal | w_jalr;
    w_tg = w_jalr ? (rs1_val + w_iimm) & ~XLEN'(1) : pc + (w_jal ? w_jimm : w_bimm);
    w_s0.v = valid_in & (w_br | w_jal | w_jalr);
    w_s0.tk = w_tk;
    w_s0.mp = w_jalr | (w_tk != pred_taken_in);
    w_s0.cn = w_br & w_f3ok;
    w_s0.ix = pc[IW+1:2];
    w_s0.tg = w_tg;
    w_s0.rd = w_tk ? w_tg : pc + XLEN'(4);
    w_nx = PIPE != 0 ? r_s1 : w_s0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_res <= '0;
      r_bc <= '0;
      r_mc <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else begin
      if (r_res.v && !stall) begin
        if (r_res.cn) begin
          r_bht[r_res.ix] <= r_res.tk ? r_bht[r_res.ix] + {1'b0, ~&r_bht[r_res.ix]} : r_bht[r_res.ix] - {1'b0, |r_bht[r_res.ix]};
          r_bc <= r_bc + CNT_W'(~&r_bc);
        end
        if (r_res.mp) r_mc <= r_mc + CNT_W'(~&r_mc);
      end
      if (flush) begin
        r_s1.v <= 1'b0;
        r_res.v <= 1'b0;
      end else if (!stall) begin
        r_s1 <= w_s0;
        if (w_nx.v) r_res <= w_nx;
        else r_res.v <= 1'b0;
      end
    end
  end
  assign w_unused = ^{lookup_pc[XLEN-1:IW+2], lookup_pc[1:0]};
  assign lookup_taken = r_bht[lookup_pc[IW+1:2]][1];
  assign res_valid = r_res.v;
  assign res_taken = r_res.tk;
  assign res_target = r_res.tg;
  assign res_redirect_pc = r_res.rd;
  assign res_mispredict = r_res.mp;
  assign branch_count = r_bc;
  assign mispredict_count = r_mc;
endmodule

// File: tb/tb_branch_resolver_v3.sv
// tb_branch_resolver_v3: checks a PIPE=0 and a PIPE=1 resolver against vectors and a reference model
module tb_branch_resolver_v3;
  logic clk = 1'b0;
  logic rst, valid_in, stall, flush, pred;
  logic [31:0] pc, instr, rs1, rs2, lpc;
  logic lt0, lt1, rv0, rv1, tk0, tk1, mp0, mp1;
  logic [31:0] tg0, tg1, rd0, rd1, bc0, mc0;
  logic [3:0] bc1, mc1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  branch_resolver_v3 #(.XLEN(32), .PIPE(0), .BHT_ENTRIES(16), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush), .pc(pc), .instr(instr),
    .rs1_val(rs1), .rs2_val(rs2), .pred_taken_in(pred), .lookup_pc(lpc), .lookup_taken(lt0),
    .res_valid(rv0), .res_taken(tk0), .res_target(tg0), .res_redirect_pc(rd0), .res_mispredict(mp0),
    .branch_count(bc0), .mispredict_count(mc0));
  branch_resolver_v3 #(.XLEN(32), .PIPE(1), .BHT_ENTRIES(8), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush), .pc(pc), .instr(instr),
    .rs1_val(rs1), .rs2_val(rs2), .pred_taken_in(pred), .lookup_pc(lpc), .lookup_taken(lt1),
    .res_valid(rv1), .res_taken(tk1), .res_target(tg1), .res_redirect_pc(rd1), .res_mispredict(mp1),
    .branch_count(bc1), .mispredict_count(mc1));
  typedef struct {
    logic v, tk, mp, cn, tgok;
    logic [31:0] pc, tg, rd;
  } exp_t;
  typedef struct {
    logic [31:0] pc, ins, a, b;
    logic pr, v, tk, mp, tgok;
    logic [31:0] tg, rd;
  } vec_t;
  exp_t out_e[2];
  exp_t mid;
  int bht[2][16];
  longint cb[2], cm[2];
  vec_t tv[11];
  function automatic int nent(input int d);
    return d != 0 ? 8 : 16;
  endfunction
  function automatic longint cap(input int d);
    return d != 0 ? 64'd15 : 64'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction
  function automatic exp_t ref_res();
    exp_t e;
    logic signed [31:0] bimm, jimm, iimm;
    bimm = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    jimm = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    iimm = 32'($signed(instr[31:20]));
    e = '{default: 0};
    e.pc = pc;
    e.tgok = 1'b1;
    case (instr[6:0])
      7'b1100011: begin
        e.v = valid_in;
        e.cn = 1'b1;
        case (instr[14:12])
          3'd0: e.tk = rs1 == rs2;
          3'd1: e.tk = rs1 != rs2;
          3'd4: e.tk = $signed(rs1) < $signed(rs2);
          3'd5: e.tk = $signed(rs1) >= $signed(rs2);
          3'd6: e.tk = rs1 < rs2;
          3'd7: e.tk = rs1 >= rs2;
          default: begin
            e.tk = 1'b0;
            e.cn = 1'b0;
            e.tgok = 1'b0;
          end
        endcase
        e.tg = pc + bimm;
        e.mp = e.tk != pred;
      end
      7'b1101111: begin
        e.v = valid_in;
        e.tk = 1'b1;
        e.tg = pc + jimm;
        e.mp = !pred;
      end
      7'b1100111: begin
        e.v = valid_in;
        e.tk = 1'b1;
        e.tg = (rs1 + iimm) & 32'hFFFF_FFFE;
        e.mp = 1'b1;
      end
      default: e.v = 1'b0;
    endcase
    e.rd = e.tk ? e.tg : pc + 32'd4;
    return e;
  endfunction
  task automatic model_step();
    exp_t e;
    e = ref_res();
    for (int d = 0; d < 2; d++) begin
      int k;
      exp_t nx;
      k = int'((out_e[d].pc >> 2) % nent(d));
      if (rst) begin
        out_e[d] = '{default: 0};
        mid.v = 1'b0;
        for (int j = 0; j < 16; j++) bht[d][j] = 1;
        cb[d] = 0;
        cm[d] = 0;
      end else begin
        if (out_e[d].v && !stall) begin
          if (out_e[d].cn) begin
            bht[d][k] = out_e[d].tk ? (bht[d][k] < 3 ? bht[d][k] + 1 : 3) : (bht[d][k] > 0 ? bht[d][k] - 1 : 0);
            if (cb[d] < cap(d)) cb[d]++;
          end
          if (out_e[d].mp && cm[d] < cap(d)) cm[d]++;
        end
        if (flush) begin
          out_e[d].v = 1'b0;
          if (d == 1) mid.v = 1'b0;
        end else if (!stall) begin
          nx = d != 0 ? mid : e;
          if (nx.v) out_e[d] = nx;
          else out_e[d].v = 1'b0;
          if (d == 1) mid = e;
        end
      end
    end
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic v, t, m, l;
      logic [31:0] g, r;
      logic [63:0] b, c;
      v = d != 0 ? rv1 : rv0;
      t = d != 0 ? tk1 : tk0;
      m = d != 0 ? mp1 : mp0;
      l = d != 0 ? lt1 : lt0;
      g = d != 0 ? tg1 : tg0;
      r = d != 0 ? rd1 : rd0;
      b = d != 0 ? 64'(bc1) : 64'(bc0);
      c = d != 0 ? 64'(mc1) : 64'(mc0);
      chk($sformatf("m%0d_valid", d), 64'(v), 64'(out_e[d].v));
      if (out_e[d].v) begin
        chk($sformatf("m%0d_taken", d), 64'(t), 64'(out_e[d].tk));
        chk($sformatf("m%0d_mispredict", d), 64'(m), 64'(out_e[d].mp));
        chk($sformatf("m%0d_redirect", d), 64'(r), 64'(out_e[d].rd));
        if (out_e[d].tgok) chk($sformatf("m%0d_target", d), 64'(g), 64'(out_e[d].tg));
      end
      chk($sformatf("m%0d_branch_count", d), b, 64'(cb[d]));
      chk($sformatf("m%0d_mispredict_count", d), c, 64'(cm[d]));
      chk($sformatf("m%0d_lookup", d), 64'(l), 64'(bht[d][int'((lpc >> 2) % nent(d))] >= 2));
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic issue(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic pr);
    pc = p;
    instr = ins;
    rs1 = a;
    rs2 = b;
    pred = pr;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    logic [31:0] snap;
    logic pat_tk [7];
    logic pat_ex [7];
    rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; pred = 1'b0;
    pc = '0; instr = '0; rs1 = '0; rs2 = '0; lpc = 32'h40;
    tv[0]  = '{32'h100, enc_b(3'b000, 13'd16), 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h110, 32'h110};
    tv[1]  = '{32'h200, enc_b(3'b100, 13'h1FF8), 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1F8, 32'h1F8};
    tv[2]  = '{32'h200, enc_b(3'b110, 13'h1FF8), 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1F8, 32'h204};
    tv[3]  = '{32'h300, enc_b(3'b101, 13'h20), 32'd7, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h320, 32'h320};
    tv[4]  = '{32'h400, enc_b(3'b001, 13'd4), 32'd3, 32'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h404, 32'h404};
    tv[5]  = '{32'h500, enc_b(3'b111, 13'd8), 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h508, 32'h504};
    tv[6]  = '{32'h600, enc_i(12'd2), 32'h2001, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2002, 32'h2002};
    tv[7]  = '{32'h700, enc_j(21'h1FFF00), 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h600};
    tv[8]  = '{32'h10, enc_j(21'h000800), 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h810, 32'h810};
    tv[9]  = '{32'h800, enc_b(3'b010, 13'd8), 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h804};
    tv[10] = '{32'h900, 32'h0010_0093, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tick();
    rst = 1'b0;
    chk("reset_taken", 64'(tk0), 64'd0);
    chk("reset_target", 64'(tg0), 64'd0);
    chk("reset_mispredict", 64'(mp1), 64'd0);
    for (int i = 0; i < 11; i++) begin
      issue(tv[i].pc, tv[i].ins, tv[i].a, tv[i].b, tv[i].pr);
      chk($sformatf("tbl%0d_valid", i), 64'(rv0), 64'(tv[i].v));
      if (tv[i].v) begin
        chk($sformatf("tbl%0d_taken", i), 64'(tk0), 64'(tv[i].tk));
        chk($sformatf("tbl%0d_mispredict", i), 64'(mp0), 64'(tv[i].mp));
        chk($sformatf("tbl%0d_redirect", i), 64'(rd0), 64'(tv[i].rd));
        if (tv[i].tgok) chk($sformatf("tbl%0d_target", i), 64'(tg0), 64'(tv[i].tg));
      end
      tick();
      if (i == 0) chk("first_mispredict_count", 64'(mc0), 64'd1);
      tick();
    end
    do_reset();
    lpc = 32'h40;
    pat_tk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pat_ex = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      issue(32'h40, enc_b(3'b000, 13'd8), 32'd1, pat_tk[i] ? 32'd1 : 32'd2, 1'b0);
      repeat (3) tick();
      chk($sformatf("bht_step%0d_p0", i), 64'(lt0), 64'(pat_ex[i]));
      chk($sformatf("bht_step%0d_p1", i), 64'(lt1), 64'(pat_ex[i]));
    end
    do_reset();
    issue(32'h80, enc_b(3'b000, 13'd8), 32'd1, 32'd1, 1'b1);
    issue(32'h84, enc_b(3'b000, 13'd8), 32'd1, 32'd1, 1'b1);
    snap = tg1;
    stall = 1'b1;
    valid_in = 1'b1;
    pc = 32'hC0;
    repeat (2) begin
      tick();
      chk("stall_hold_valid", 64'(rv1), 64'd1);
      chk("stall_hold_target", 64'(tg1), 64'(snap));
      chk("stall_no_count", 64'(bc1), 64'd0);
    end
    stall = 1'b0;
    valid_in = 1'b0;
    repeat (4) tick();
    chk("stall_bc_p0", 64'(bc0), 64'd2);
    chk("stall_bc_p1", 64'(bc1), 64'd2);
    do_reset();
    issue(32'h80, enc_b(3'b000, 13'd8), 32'd1, 32'd1, 1'b1);
    pc = 32'h84;
    valid_in = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_valid_p1", 64'(rv1), 64'd0);
    flush = 1'b0;
    valid_in = 1'b0;
    repeat (3) tick();
    chk("flush_bc_p0", 64'(bc0), 64'd1);
    chk("flush_bc_p1", 64'(bc1), 64'd0);
    issue(32'h80, enc_b(3'b000, 13'd8), 32'd1, 32'd1, 1'b0);
    valid_in = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_in = 1'b0;
    chk("rst_valid_p0", 64'(rv0), 64'd0);
    chk("rst_valid_p1", 64'(rv1), 64'd0);
    chk("rst_mc_p0", 64'(mc0), 64'd0);
    chk("rst_lookup_p0", 64'(lt0), 64'd0);
    for (int n = 0; n < 3000; n++) begin
      int r, k;
      r = $urandom_range(0, 99);
      rst = r == 0;
      flush = r >= 1 && r < 6;
      stall = r >= 6 && r < 20;
      valid_in = $urandom_range(0, 3) != 0;
      k = $urandom_range(0, 9);
      instr = k < 6 ? enc_b(3'($urandom), 13'($urandom)) : k == 6 ? enc_j(21'($urandom)) : k == 7 ? enc_i(12'($urandom)) : $urandom;
      pc = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 63)) << 2;
      rs1 = $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 3));
      rs2 = $urandom_range(0, 2) == 0 ? rs1 : $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 3));
      pred = 1'($urandom_range(0, 1));
      lpc = 32'($urandom_range(0, 63)) << 2;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
